// File: rtl/lsu_writeback.sv
// lsu_writeback: multi-cycle load/store unit that sits between execute and
// the register-file write port. It accepts one load or store per transaction
// and runs a valid/ready request to data memory. It then waits for the
// response, formats load data and retires the instruction with a done pulse.
// Misaligned accesses, illegal encodings and response timeouts retire with
// err instead.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        execute hand-off (ready only while idle)
//   req_instr/addr/wdata       instruction, effective byte address, rs2 data
//   mem_req_valid/ready        memory request handshake
//   mem_we/addr/wstrb/wdata    request payload (word address, byte lanes)
//   mem_rsp_valid, mem_rdata   read data or write acknowledge
//   rf_w_en/rd_id/wdata        register-file write port (one-cycle pulse)
//   busy                       stall to the core while not idle
//   done, err                  retire pulse; err marks a faulted retire
module lsu_writeback #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_instr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata,
  output logic              rf_w_en,
  output logic [4:0]        rf_rd_id,
  output logic [31:0]       rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_WB,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       offset_q;
  logic [4:0]       rd_q;
  logic             is_load_q;

  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_legal;
  logic        in_misaligned;
  logic [3:0]  in_wstrb;
  logic [31:0] in_wdata_lanes;
  logic [31:0] rsp_shifted;
  logic [31:0] load_result;
  logic        timeout_hit;

  // Only opcode, funct3 and rd of the instruction matter to this unit.
  logic unused_instr_bits;
  assign unused_instr_bits = ^req_instr[31:15];

  assign req_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign mem_req_valid = (state == S_REQ);
  assign rf_rd_id      = rd_q;

  // Decode the incoming request and pre-compute the store lane layout so the
  // memory payload can be registered once on acceptance and held in REQ.
  always_comb begin
    in_opcode   = req_instr[6:0];
    in_funct3   = req_instr[14:12];
    in_is_load  = (in_opcode == OP_LOAD);
    in_is_store = (in_opcode == OP_STORE);

    in_legal = 1'b0;
    if (in_is_load) begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_legal = 1'b1;
        default:                                in_legal = 1'b0;
      endcase
    end else if (in_is_store) begin
      in_legal = !in_funct3[2] && (in_funct3[1:0] != 2'b11);
    end

    case (in_funct3[1:0])
      2'b01:   in_misaligned = req_addr[0];
      2'b10:   in_misaligned = (req_addr[1:0] != 2'b00);
      default: in_misaligned = 1'b0;
    endcase

    in_wstrb       = 4'b0000;
    in_wdata_lanes = 32'h0000_0000;
    if (in_is_store) begin
      case (in_funct3[1:0])
        2'b00: begin
          in_wstrb       = 4'b0001 << req_addr[1:0];
          in_wdata_lanes = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          in_wstrb       = req_addr[1] ? 4'b1100 : 4'b0011;
          in_wdata_lanes = {2{req_wdata[15:0]}};
        end
        default: begin
          in_wstrb       = 4'b1111;
          in_wdata_lanes = req_wdata;
        end
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0, then extend. funct3[2]
  // selects zero extension (lbu/lhu).
  always_comb begin
    rsp_shifted = mem_rdata >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  load_result = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_result = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  load_result = {24'h000000, rsp_shifted[7:0]};
      3'b101:  load_result = {16'h0000, rsp_shifted[15:0]};
      default: load_result = rsp_shifted;
    endcase
  end

  // The counter holds the number of completed WAIT_RSP cycles. The timeout
  // fires at the end of the TIMEOUT-th cycle, so a response in that same
  // cycle is still taken.
  assign timeout_hit = (TIMEOUT != 0) &&
                       ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT));

  // Single FSM. The retire pulses are set on the transition into WB, DONE
  // or ERR, so they are registered and last exactly the one cycle spent in
  // that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      funct3_q  <= 3'b000;
      offset_q  <= 2'b00;
      rd_q      <= 5'd0;
      is_load_q <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      rf_w_en   <= 1'b0;
      rf_wdata  <= 32'h0000_0000;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rf_w_en <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q  <= in_funct3;
            offset_q  <= req_addr[1:0];
            rd_q      <= req_instr[11:7];
            is_load_q <= in_is_load;
            mem_we    <= in_is_store;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb <= in_wstrb;
            mem_wdata <= in_wdata_lanes;
            if (!in_legal || in_misaligned) begin
              state <= S_ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state    <= S_WAIT_RSP;
            wait_cnt <= '0;
          end
        end
        S_WAIT_RSP: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (mem_rsp_valid) begin
            done <= 1'b1;
            if (is_load_q) begin
              state    <= S_WB;
              rf_wdata <= load_result;
              rf_w_en  <= (rd_q != 5'd0);
            end else begin
              state <= S_DONE;
            end
          end else if (timeout_hit) begin
            state <= S_ERR;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_writeback.sv
// tb_lsu_writeback: self-checking bench for lsu_writeback. It runs directed
// scenarios followed by randomized transactions. The expected memory payload,
// the load results and the error/timeout outcomes come from a behavioural
// model built on plain arithmetic (access size, byte offset and value ranges).
module tb_lsu_writeback;

  localparam int         ADDR_W   = 32;
  localparam int         TO       = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_instr = 32'h0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid = 1'b0;
  logic [31:0]       mem_rdata = 32'h0;
  logic              rf_w_en;
  logic [4:0]        rf_rd_id;
  logic [31:0]       rf_wdata;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  lsu_writeback #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rf_w_en(rf_w_en), .rf_rd_id(rf_rd_id), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Safety net: the scenarios are all fixed-length, so this only trips if
  // something in the bench itself goes wrong.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mkInstr(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    r[11:7]  = rd;
    r[6:0]   = op;
    return r;
  endfunction

  // Reference model: access size in bytes is 1, 2 or 4, selected by funct3.
  function automatic int accessSize(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit modelIsError(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [31:0] addr);
    bit legal;
    if (op == OP_LOAD)       legal = (f3 != 3) && (f3 != 6) && (f3 != 7);
    else if (op == OP_STORE) legal = (f3 <= 2);
    else                     legal = 1'b0;
    return !legal || ((addr % accessSize(f3)) != 0);
  endfunction

  function automatic logic [3:0] modelStrobe(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int mask;
    if (op != OP_STORE) return 4'b0000;
    mask = (1 << accessSize(f3)) - 1;
    return 4'(mask << (addr % 4));
  endfunction

  function automatic logic [31:0] modelLanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (accessSize(f3))
      1:       return (wdata & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (wdata & 32'h0000_FFFF) * 32'h0001_0001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    longint v;
    longint span;
    int     size;
    size = accessSize(f3);
    v = longint'(rdata >> (8 * (addr % 4)));
    if (size < 4) begin
      span = longint'(1) << (8 * size);
      v = v % span;
      if (f3 < 4 && v >= span / 2) v = v - span;
    end
    return 32'(v);
  endfunction

  // One complete transaction. rsp_at is the WAIT_RSP cycle in which memory
  // answers (negative: never). While the unit is busy, the bench drives
  // stray req_valid and mem_rsp_valid values that the unit must ignore.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ready_delay,
                               input int rsp_at, input logic [31:0] rdata);
    bit exp_err;
    bit timed_out;
    bit exp_wen;
    int wait_cycles;
    checkOutput("req_ready idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_instr = mkInstr(op, f3, rd);
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_instr = $urandom;
    req_addr  = $urandom;
    req_wdata = $urandom;
    exp_err = modelIsError(op, f3, addr);
    if (exp_err) begin
      checkOutput("early err {done,err,w_en,mreq}", {28'd0, done, err, rf_w_en, mem_req_valid},
                  32'b1100);
      tick();
      checkOutput("after err {busy,done,err,rdy}", {28'd0, busy, done, err, req_ready}, 32'b0001);
    end else begin
      for (int c = 0; c <= ready_delay; c++) begin
        checkOutput("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        checkOutput("mem_addr", mem_addr, addr & ~32'h3);
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, op == OP_STORE});
        checkOutput("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, modelStrobe(op, f3, addr)});
        if (op == OP_STORE) checkOutput("mem_wdata", mem_wdata, modelLanes(f3, wdata));
        mem_req_ready = (c == ready_delay);
        mem_rsp_valid = 1'($urandom);
        req_valid     = 1'($urandom);
        tick();
      end
      mem_req_ready = 1'b0;
      timed_out   = (rsp_at < 0) || (rsp_at >= TO);
      wait_cycles = timed_out ? TO : rsp_at + 1;
      for (int c = 0; c < wait_cycles; c++) begin
        checkOutput("waiting {busy,mreq,done,w_en,err}",
                    {27'd0, busy, mem_req_valid, done, rf_w_en, err}, 32'b10000);
        mem_rsp_valid = (c == rsp_at);
        mem_rdata     = (c == rsp_at) ? rdata : $urandom;
        tick();
      end
      mem_rsp_valid = 1'b0;
      exp_wen = (op == OP_LOAD) && !timed_out && (rd != 5'd0);
      checkOutput("retire {done,err,w_en}", {29'd0, done, err, rf_w_en},
                  {29'd0, 1'b1, timed_out, exp_wen});
      if (exp_wen) begin
        checkOutput("rf_rd_id", {27'd0, rf_rd_id}, {27'd0, rd});
        checkOutput("rf_wdata", rf_wdata, modelLoad(f3, addr, rdata));
      end
      req_valid = 1'b0;
      tick();
      checkOutput("idle {busy,done,err,w_en,rdy}", {27'd0, busy, done, err, rf_w_en, req_ready},
                  32'b00001);
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    int          ready_delay;
    int          rsp_at;

    #12;
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset {busy,mreq,done,err,w_en}",
                {27'd0, busy, mem_req_valid, done, err, rf_w_en}, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    checkOutput("reset rf_wdata", rf_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Directed loads: word, signed/unsigned byte at the top lane, signed half.
    applyStimulus(OP_LOAD, 3'b010, 5'd5, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(OP_LOAD, 3'b000, 5'd6, 32'h103, 32'h0, 0, 0, 32'h8011_2233);
    applyStimulus(OP_LOAD, 3'b100, 5'd7, 32'h103, 32'h0, 1, 2, 32'h8011_2233);
    applyStimulus(OP_LOAD, 3'b001, 5'd8, 32'h102, 32'h0, 0, 0, 32'h8001_5566);
    // Store half to the upper lanes with a stalled request.
    applyStimulus(OP_STORE, 3'b001, 5'd0, 32'h202, 32'h0000_ABCD, 3, 0, 32'h0);
    // Misaligned word and illegal funct3 fault straight from acceptance.
    applyStimulus(OP_LOAD, 3'b010, 5'd3, 32'h101, 32'h0, 0, 0, 32'h0);
    applyStimulus(OP_LOAD, 3'b011, 5'd3, 32'h100, 32'h0, 0, 0, 32'h0);
    // rd = 0 still runs the memory access but never writes the regfile.
    applyStimulus(OP_LOAD, 3'b010, 5'd0, 32'h180, 32'h0, 0, 1, 32'h1234_5678);
    // Timeout, and a response on the last allowed cycle winning over it.
    applyStimulus(OP_LOAD, 3'b010, 5'd4, 32'h400, 32'h0, 0, -1, 32'h0);
    applyStimulus(OP_LOAD, 3'b010, 5'd4, 32'h404, 32'h0, 0, TO - 1, 32'hCAFE_F00D);

    // Reset in the middle of WAIT_RSP.
    req_valid = 1'b1;
    req_instr = mkInstr(OP_LOAD, 3'b010, 5'd9);
    req_addr  = 32'h300;
    tick();
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset {busy,mreq,done,err,w_en,rdy}",
                {26'd0, busy, mem_req_valid, done, err, rf_w_en, req_ready}, 32'b000001);
    checkOutput("async reset mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    checkOutput("late rsp ignored {busy,done,w_en}", {29'd0, busy, done, rf_w_en}, 32'd0);
    tick();
    applyStimulus(OP_LOAD, 3'b010, 5'd9, 32'h300, 32'h0, 0, 0, 32'h0BAD_F00D);

    // Randomized transactions.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: op = OP_LOAD;
        5, 6, 7, 8:    op = OP_STORE;
        default:       op = OP_ALU;
      endcase
      f3 = (op == OP_STORE) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      ready_delay = $urandom_range(0, 3);
      rsp_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO));
      applyStimulus(op, f3, rd, addr, $urandom, ready_delay, rsp_at, $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Multi-cycle load/store unit between execute and the register-file write port.
- Takes one memory instruction (opcode 0000011 load or 0100011 store) plus its computed address and rs2 data.
- Runs a valid/ready request and response exchange with data memory, then formats load data (byte/half/word, sign/zero extension).
- Drives the regfile write port (w_en, rd_id, write data) and stalls the core while busy.

Parameters:
- ADDR_W, 32: byte-address width of mem_addr and req_addr.
- TIMEOUT, 255: max cycles in WAIT_RSP before aborting with err; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute presents a memory instruction.
- req_ready  out  1  high only in IDLE.
- req_instr  in  32  instruction; opcode [6:0], funct3 [14:12], rd [11:7].
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  store data (rs2 value).
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  word-aligned address, req_addr with [1:0] = 0.
- mem_wstrb  out  4  byte enables; 0000 for loads.
- mem_wdata  out  32  store data shifted into byte lanes.
- mem_rsp_valid  in  1  read data or write acknowledge.
- mem_rdata  in  32  read word.
- rf_w_en  out  1  regfile write enable, one-cycle pulse.
- rf_rd_id  out  5  destination register.
- rf_wdata  out  32  formatted load result.
- busy  out  1  stall to core; high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when an instruction retires (including on error).
- err  out  1  one-cycle pulse, coincident with done, for misaligned access, illegal funct3, or timeout.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0 except req_ready = 1; timeout counter 0; latched fields cleared.
- IDLE:
  - If req_valid, latch instr, addr, wdata and decode.
  - Legal loads: lb 000, lh 001, lw 010, lbu 100, lhu 101.
  - Legal stores: sb 000, sh 001, sw 010.
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0. Misaligned, illegal funct3 or illegal opcode go to ERR; otherwise go to REQ.
- REQ:
  - mem_req_valid = 1; mem_we, mem_addr, mem_wstrb, mem_wdata held stable until mem_req_ready.
  - On ready, go to WAIT_RSP and clear the counter.
  - Store lanes: sb wstrb = 1 << addr[1:0], byte replicated to all lanes. sh wstrb = 0011 or 1100, half replicated to both halves. sw wstrb = 1111.
- WAIT_RSP:
  - Counter increments each cycle.
  - On mem_rsp_valid: a load latches mem_rdata and goes to WB; a store goes to DONE.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT without a response, go to ERR.
  - A response arriving in the same cycle the counter hits TIMEOUT wins (no err).
- WB:
  - rf_wdata = selected lane, shifted by addr[1:0], sign- or zero-extended per funct3.
  - rf_w_en = 1 only if rd != 0; rf_rd_id = rd. done pulses; next state IDLE.
- DONE: done pulses; next state IDLE.
- ERR: done = 1, err = 1, rf_w_en = 0, no memory request issued; next state IDLE.
- Latency, load: accept, REQ (≥1 cycle), WAIT_RSP (≥1), WB. Minimum 4 cycles from acceptance to rf_w_en.
- mem_rsp_valid outside WAIT_RSP is ignored.
- req_valid while busy is ignored, since req_ready = 0.
- rf_w_en, done and err are registered outputs: glitch-free, exactly one cycle each.
- Reset asserted mid-transaction aborts immediately. No rf_w_en or done is produced, and the memory must tolerate the dropped request.

Test Plan:
- lw, addr 0x100, rd = 5, memory returns 0xDEADBEEF after 2 cycles -> mem_addr 0x100, wstrb 0000; one rf_w_en pulse with rf_rd_id 5, rf_wdata 0xDEADBEEF; done; busy falls the next cycle.
- lb then lbu, addr 0x103, rdata 0x80112233 -> rf_wdata 0xFFFFFF80, then 0x00000080. lh at 0x102 with rdata 0x8001xxxx -> 0xFFFF8001.
- sh, addr 0x202, wdata 0x0000ABCD, mem_req_ready delayed 3 cycles -> mem_addr 0x200, wstrb 1100, wdata 0xABCDABCD stable through the stall; done on the ack; rf_w_en never asserted.
- lw at 0x101, and funct3 011 load -> err + done pulse one cycle after accept; mem_req_valid never asserted.
- lw with rd = 0 -> full memory transaction, done pulses, rf_w_en stays 0. Same with TIMEOUT = 4 and no response -> err after 4 cycles in WAIT_RSP.
- rst_n dropped during WAIT_RSP -> all outputs 0 asynchronously, req_ready = 1 after release; a late mem_rsp_valid is ignored; the next lw completes normally.
